// File: rtl/fixed_prio_arbiter.sv
// fixed_prio_arbiter
//   Fixed-priority arbiter for NUM_REQ requesters sharing one resource.
//   The highest-index active request wins. The grant is registered, so it
//   follows req by exactly one cycle, and there is no combinational path
//   from req to grant. If lock is high, the current owner keeps the grant
//   for as long as its own req stays high.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high; overrides req and lock
//   req          request vector, bit i = requester i
//   lock         1 = keep the current owner while its req stays high
//   grant        registered one-hot grant, all-zero = no grant
//   grant_valid  registered, equals |grant
//   grant_idx    registered binary index of the granted bit, 0 when none
module fixed_prio_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               lock,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [NUM_REQ-1:0] sel;
  logic [IDX_W-1:0]   sel_idx;
  logic               hold;

  // The scan runs upward, so the last set bit it sees is the highest one.
  // That bit overrides any lower ones found earlier.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        sel     = '0;
        sel[i]  = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Lock only holds a live owner. If there is no grant, or the owner has
  // dropped its req, the arbiter falls back to normal priority selection.
  assign hold = lock && grant_valid && |(grant & req);

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else if (!hold) begin
      grant       <= sel;
      grant_valid <= |req;
      grant_idx   <= sel_idx;
    end
  end

endmodule

// File: tb/tb_fixed_prio_arbiter.sv
module tb_fixed_prio_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         lock;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [W-1:0] grant_idx;

  int checks = 0;
  int errors = 0;

  fixed_prio_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         lock;
    logic [N-1:0] exp_grant;
    logic [W-1:0] exp_idx;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[8];

  // Drive the inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic step(input logic r, input logic [N-1:0] q, input logic l);
    rst = r; req = q; lock = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] eg,
                       input logic [W-1:0] ei, input logic ev);
    checks++;
    if (grant !== eg) begin
      errors++;
      $display("FAIL %s grant: got %b expected %b", name, grant, eg);
    end
    checks++;
    if (grant_idx !== ei) begin
      errors++;
      $display("FAIL %s grant_idx: got %0d expected %0d", name, grant_idx, ei);
    end
    checks++;
    if (grant_valid !== ev) begin
      errors++;
      $display("FAIL %s grant_valid: got %b expected %b", name, grant_valid, ev);
    end
  endtask

  // Reference model: scan down from the top bit and stop at the first set bit.
  function automatic logic [N-1:0] top_bit(input logic [N-1:0] q);
    for (int i = N - 1; i >= 0; i--)
      if (q[i]) return N'(1) << i;
    return '0;
  endfunction

  function automatic logic [W-1:0] enc(input logic [N-1:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  initial begin
    rst = 1'b1; req = '0; lock = 1'b0;

    // Reset with every req active, followed by the basic priority sequence.
    vecs[0] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[1] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[3] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[4] = '{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[5] = '{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[6] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[7] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].lock);
      check($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_idx, vecs[i].exp_valid);
    end

    // Without lock, a higher-index request preempts the current owner.
    step(1'b0, 4'b0001, 1'b0); check("preempt_own", 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0101, 1'b0); check("preempt_new", 4'b0100, 2'd2, 1'b1);

    // With lock, the owner holds until its req drops.
    step(1'b0, 4'b0000, 1'b1); check("lock_idle",  4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0010, 1'b1); check("lock_own",   4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1010, 1'b1); check($sformatf("lock_hold%0d", i), 4'b0010, 2'd1, 1'b1);
    end
    step(1'b0, 4'b1000, 1'b1); check("lock_drop",  4'b1000, 2'd3, 1'b1);

    // Reset asserted mid-operation, then released.
    step(1'b0, 4'b1111, 1'b1); check("mid_pre",    4'b1000, 2'd3, 1'b1);
    step(1'b1, 4'b1111, 1'b1); check("mid_rst",    4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b1); check("mid_post",   4'b1000, 2'd3, 1'b1);

    // Random req/lock/rst traffic compared against the reference model.
    begin
      logic [N-1:0] m;
      logic [N-1:0] q;
      logic l, r;
      m = 4'b1000;
      for (int c = 0; c < 10000; c++) begin
        q = N'($urandom);
        l = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 63) == 0);
        if (r)                                m = '0;
        else if (l && m != '0 && (m & q) != '0) m = m;
        else                                  m = top_bit(q);
        step(r, q, l);
        checks++;
        if (!$onehot0(grant)) begin
          errors++;
          $display("FAIL rand_onehot cyc %0d: got %b expected one-hot or zero", c, grant);
        end
        check($sformatf("rand%0d", c), m, enc(m), m != '0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
